vfd_scan_capture: RTL

VFD_SCAN_CAPTURE -- requirements
Module: vfd_scan_capture

---
 rtl/ucom_pkg.sv | 16 +
 rtl/vfd_scan_capture_if.sv | 37 +++
 rtl/vfd_scan_capture_onehot_idx.sv | 19 +
 rtl/vfd_scan_capture.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/ucom_pkg.sv
// Shared constants and types for the VFD scan-capture slice: grid/segment
// widths, default timing parameters and the capture FSM state encoding.
package ucom_pkg;

  localparam int NUM_GRIDS  = 8;
  localparam int SEG_W      = 16;
  localparam int DEF_SETTLE = 4;
  localparam int DEF_DECAY  = 1024;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } vfd_state_e;

endpackage

// File: rtl/vfd_scan_capture_if.sv
// MCU port bundle seen by the VFD scan capture block (segments, grids, readback).
// Optional keypad signals exist only when KEYPAD_EN is defined.
interface vfd_scan_capture_if;
  import ucom_pkg::*;

  logic [3:0]           prtC;
  logic [3:0]           prtD;
  logic [3:0]           prtG;
  logic [3:0]           prtH;
  logic [3:0]           prtE;
  logic [3:0]           prtF;
  logic [2:0]           rd_addr;
  logic [SEG_W-1:0]     rd_data;
  logic [NUM_GRIDS-1:0] dig_valid;
  logic                 frame;
`ifdef KEYPAD_EN
  logic [31:0]          keys;
  logic [3:0]           key_rows;
`endif

  modport master (
    output prtC, prtD, prtG, prtH, prtE, prtF, rd_addr,
    input  rd_data, dig_valid, frame
`ifdef KEYPAD_EN
    , output keys, input key_rows
`endif
  );

  modport slave (
    input  prtC, prtD, prtG, prtH, prtE, prtF, rd_addr,
    output rd_data, dig_valid, frame
`ifdef KEYPAD_EN
    , input keys, output key_rows
`endif
  );

endinterface

// File: rtl/vfd_scan_capture_onehot_idx.sv
// Grid strobe decoder: bit index of the active grid plus a one-hot flag.
module onehot_idx
  import ucom_pkg::*;
(
  input  logic [NUM_GRIDS-1:0] grid,
  output logic [2:0]           idx,
  output logic                 is_onehot
);

  // Index is only meaningful when exactly one strobe is high
  always_comb begin
    idx = 3'd0;
    for (int i = 0; i < NUM_GRIDS; i++) begin
      idx = idx | (grid[i] ? 3'(i) : 3'd0);
    end
    is_onehot = (grid != 8'd0) && ((grid & (grid - 8'd1)) == 8'd0);
  end

endmodule

// File: rtl/vfd_scan_capture.sv
// Captures multiplexed VFD digits from MCU port activity into a decaying buffer.
// Optional keypad row sensing is built when KEYPAD_EN is defined.
module vfd_scan_capture
  import ucom_pkg::*;
#(
  parameter int SETTLE = DEF_SETTLE,
  parameter int DECAY  = DEF_DECAY
)
(
  input logic               clk,
  input logic               reset,
  vfd_scan_capture_if.slave bus
);

  localparam int CNT_W = $clog2(SETTLE + 1);
  localparam int DEC_W = $clog2(DECAY + 1);
  // The IDLE load edge already counts as the first stable cycle
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((SETTLE >= 2) ? (SETTLE - 2) : 0);
  localparam logic [DEC_W-1:0] DEC_LAST = DEC_W'(DECAY - 1);
  localparam logic [DEC_W-1:0] DEC_MAX  = DEC_W'(DECAY);

  logic [NUM_GRIDS-1:0] grid_s;
  logic [SEG_W-1:0]     seg_s;
  logic [2:0]           idx_s;
  logic                 is_onehot_s;
  logic                 match_s;
  logic                 cap_s;
  logic [NUM_GRIDS-1:0] decay_hit_s;
  logic [SEG_W-1:0]     rd_next_s;

  vfd_state_e           state_r;
  logic [NUM_GRIDS-1:0] grid_snap_r;
  logic [SEG_W-1:0]     seg_snap_r;
  logic [CNT_W-1:0]     cnt_r;
  logic [SEG_W-1:0]     buf_r [NUM_GRIDS];
  logic [DEC_W-1:0]     dec_r [NUM_GRIDS];
  logic [NUM_GRIDS-1:0] valid_r;
  logic [SEG_W-1:0]     rd_data_r;
  logic                 frame_r;

  assign grid_s = {bus.prtF, bus.prtE};
  assign seg_s  = {bus.prtH, bus.prtG, bus.prtD, bus.prtC};

  onehot_idx u_onehot_idx (
    .grid      (grid_s),
    .idx       (idx_s),
    .is_onehot (is_onehot_s)
  );

  // Capture decision, decay expiry and readback forwarding
  always_comb begin
    match_s = (grid_s == grid_snap_r) && (seg_s == seg_snap_r);
    cap_s   = (state_r == ST_SETTLE) && is_onehot_s && match_s && (cnt_r >= CNT_LAST);
    for (int i = 0; i < NUM_GRIDS; i++) begin
      decay_hit_s[i] = valid_r[i] && (dec_r[i] == DEC_LAST);
    end
    if (cap_s && (idx_s == bus.rd_addr)) begin
      rd_next_s = seg_s;
    end else if (decay_hit_s[bus.rd_addr]) begin
      rd_next_s = '0;
    end else begin
      rd_next_s = buf_r[bus.rd_addr];
    end
  end

  // Stability FSM: snapshot, count matching cycles, hold until inputs move
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      grid_snap_r <= '0;
      seg_snap_r  <= '0;
      cnt_r       <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (is_onehot_s) begin
            grid_snap_r <= grid_s;
            seg_snap_r  <= seg_s;
            cnt_r       <= '0;
            state_r     <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (!is_onehot_s) begin
            state_r <= ST_IDLE;
          end else if (!match_s) begin
            grid_snap_r <= grid_s;
            seg_snap_r  <= seg_s;
            cnt_r       <= '0;
          end else if (cnt_r >= CNT_LAST) begin
            cnt_r   <= '0;
            state_r <= ST_HOLD;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_HOLD: begin
          if (match_s) begin
            state_r <= ST_HOLD;
          end else if (is_onehot_s) begin
            grid_snap_r <= grid_s;
            seg_snap_r  <= seg_s;
            cnt_r       <= '0;
            state_r     <= ST_SETTLE;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= '0;
        end
      endcase
    end
  end

  // Digit buffer, per-digit decay timers and registered readback; capture beats decay
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_GRIDS; i++) begin
        buf_r[i] <= '0;
        dec_r[i] <= '0;
      end
      valid_r   <= '0;
      rd_data_r <= '0;
      frame_r   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_GRIDS; i++) begin
        if (cap_s && (idx_s == 3'(i))) begin
          buf_r[i]   <= seg_s;
          valid_r[i] <= 1'b1;
          dec_r[i]   <= '0;
        end else if (decay_hit_s[i]) begin
          buf_r[i]   <= '0;
          valid_r[i] <= 1'b0;
          dec_r[i]   <= DEC_MAX;
        end else if (valid_r[i]) begin
          dec_r[i] <= dec_r[i] + DEC_W'(1);
        end
      end
      rd_data_r <= rd_next_s;
      frame_r   <= cap_s && (idx_s == 3'd7);
    end
  end

  assign bus.rd_data   = rd_data_r;
  assign bus.dig_valid = valid_r;
  assign bus.frame     = frame_r;

`ifdef KEYPAD_EN
  logic [3:0] key_or_s;
  logic [3:0] key_rows_r;

  // Rows of every currently strobed grid merge onto the shared return lines
  always_comb begin
    key_or_s = 4'd0;
    for (int g = 0; g < NUM_GRIDS; g++) begin
      key_or_s = key_or_s | (bus.keys[4*g +: 4] & {4{grid_s[g]}});
    end
  end

  // Registered key row sample
  always_ff @(posedge clk) begin
    if (reset) begin
      key_rows_r <= 4'd0;
    end else begin
      key_rows_r <= key_or_s;
    end
  end

  assign bus.key_rows = key_rows_r;
`endif

endmodule
